// File: rtl/vpu_cmd_queue.sv
// rtl/vpu_cmd_queue.sv - command FIFO between VPU decode stage and VPU engine, with GETOBJ issue barrier
module vpu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_start,
    input  logic                         in_fill,
    input  logic [3:0]                   in_op,
    input  logic [3:0]                   in_code,
    input  logic [4:0]                   in_obj_num,
    input  logic [1:0]                   in_obj_type,
    input  logic [2:0]                   in_obj_color,
    input  logic [15:0]                  in_v0,
    input  logic [15:0]                  in_v1,
    input  logic [15:0]                  in_v2,
    input  logic [15:0]                  in_v3,
    input  logic [15:0]                  in_v4,
    input  logic [15:0]                  in_v5,
    input  logic [15:0]                  in_v6,
    input  logic [15:0]                  in_v7,
    input  logic [15:0]                  in_ro,
    output logic                         stall,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         cmd_fill,
    output logic [3:0]                   cmd_op,
    output logic [3:0]                   cmd_code,
    output logic [4:0]                   cmd_obj_num,
    output logic [1:0]                   cmd_obj_type,
    output logic [2:0]                   cmd_obj_color,
    output logic [15:0]                  cmd_v0,
    output logic [15:0]                  cmd_v1,
    output logic [15:0]                  cmd_v2,
    output logic [15:0]                  cmd_v3,
    output logic [15:0]                  cmd_v4,
    output logic [15:0]                  cmd_v5,
    output logic [15:0]                  cmd_v6,
    output logic [15:0]                  cmd_v7,
    output logic [15:0]                  cmd_ro,
    input  logic                         obj_done,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         err_overlap
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + 4 + 4 + 5 + 2 + 3 + 9 * 16;
    localparam logic [3:0] OP_GETOBJ = 4'hF;

    typedef enum logic {
        ST_ISSUE,
        ST_WAIT_OBJ
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [EW-1:0]   in_entry;
    logic            push, pop;

    // A FILL flag wins when start and fill overlap, so fill alone feeds the entry.
    assign in_entry = {in_fill, in_op, in_code, in_obj_num, in_obj_type, in_obj_color,
                       in_v0, in_v1, in_v2, in_v3, in_v4, in_v5, in_v6, in_v7, in_ro};

    assign {cmd_fill, cmd_op, cmd_code, cmd_obj_num, cmd_obj_type, cmd_obj_color,
            cmd_v0, cmd_v1, cmd_v2, cmd_v3, cmd_v4, cmd_v5, cmd_v6, cmd_v7, cmd_ro} = mem_q[rd_ptr_q];

    assign stall       = (count_q == CW'(DEPTH));
    assign cmd_valid   = (count_q != '0) && (state_q == ST_ISSUE);
    assign count       = count_q;
    assign err_overlap = err_q;

    // Push is gated on registered fullness only; a same-cycle pop does not free a slot.
    assign push = (in_start || in_fill) && !stall;
    assign pop  = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        err_d    = err_q | (in_start & in_fill);

        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        case (state_q)
            ST_ISSUE: begin
                if (pop && (cmd_op == OP_GETOBJ) && !cmd_fill) begin
                    state_d = ST_WAIT_OBJ;
                end
            end
            ST_WAIT_OBJ: begin
                if (obj_done) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ISSUE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_vpu_cmd_queue.sv
// tb/tb_vpu_cmd_queue.sv - directed and randomized checks of vpu_cmd_queue against a queue-based model
module tb_vpu_cmd_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        fill;
        logic [3:0]  op;
        logic [3:0]  code;
        logic [4:0]  num;
        logic [1:0]  typ;
        logic [2:0]  color;
        logic [15:0] v0;
        logic [15:0] v7;
        logic [15:0] ro;
    } ent_t;

    logic clk = 1'b0;
    logic rst, in_start, in_fill, cmd_ready, obj_done;
    logic [3:0] in_op, in_code;
    logic [4:0] in_obj_num;
    logic [1:0] in_obj_type;
    logic [2:0] in_obj_color;
    logic [15:0] in_v0, in_v1, in_v2, in_v3, in_v4, in_v5, in_v6, in_v7, in_ro;
    logic stall, cmd_valid, cmd_fill, err_overlap;
    logic [3:0] cmd_op, cmd_code;
    logic [4:0] cmd_obj_num;
    logic [1:0] cmd_obj_type;
    logic [2:0] cmd_obj_color;
    logic [15:0] cmd_v0, cmd_v1, cmd_v2, cmd_v3, cmd_v4, cmd_v5, cmd_v6, cmd_v7, cmd_ro;
    logic [2:0] count;

    int n_pass = 0;
    int n_total = 0;

    ent_t mq[$];
    bit   m_wait = 0;
    bit   m_err = 0;

    vpu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_fill(in_fill),
        .in_op(in_op), .in_code(in_code), .in_obj_num(in_obj_num),
        .in_obj_type(in_obj_type), .in_obj_color(in_obj_color),
        .in_v0(in_v0), .in_v1(in_v1), .in_v2(in_v2), .in_v3(in_v3),
        .in_v4(in_v4), .in_v5(in_v5), .in_v6(in_v6), .in_v7(in_v7), .in_ro(in_ro),
        .stall(stall), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fill(cmd_fill), .cmd_op(cmd_op), .cmd_code(cmd_code),
        .cmd_obj_num(cmd_obj_num), .cmd_obj_type(cmd_obj_type), .cmd_obj_color(cmd_obj_color),
        .cmd_v0(cmd_v0), .cmd_v1(cmd_v1), .cmd_v2(cmd_v2), .cmd_v3(cmd_v3),
        .cmd_v4(cmd_v4), .cmd_v5(cmd_v5), .cmd_v6(cmd_v6), .cmd_v7(cmd_v7), .cmd_ro(cmd_ro),
        .obj_done(obj_done), .count(count), .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic present(input bit start, input bit fill, input logic [3:0] op,
                           input logic [4:0] num, input logic [2:0] color, input logic [15:0] v0);
        in_start = start;  in_fill = fill;  in_op = op;  in_code = op ^ 4'h5;
        in_obj_num = num;  in_obj_type = num[1:0];  in_obj_color = color;
        in_v0 = v0;  in_v1 = v0 + 16'd1;  in_v2 = v0 + 16'd2;  in_v3 = v0 + 16'd3;
        in_v4 = v0 + 16'd4;  in_v5 = v0 + 16'd5;  in_v6 = v0 + 16'd6;
        in_v7 = ~v0;  in_ro = {v0[7:0], v0[15:8]};
    endtask

    task automatic idle();
        present(1'b0, 1'b0, 4'h0, 5'h0, 3'h0, 16'h0);
    endtask

    // Advance one clock and update the model from the inputs that were presented for that edge.
    task automatic cycle();
        bit   pop, push;
        ent_t e, h;
        pop  = (mq.size() != 0) && !m_wait && cmd_ready;
        push = (in_start || in_fill) && (mq.size() < DEPTH);
        e = '{fill: in_fill, op: in_op, code: in_code, num: in_obj_num, typ: in_obj_type,
              color: in_obj_color, v0: in_v0, v7: in_v7, ro: in_ro};
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_wait = 0;
            m_err  = 0;
        end else begin
            if (in_start && in_fill) m_err = 1;
            if (m_wait && obj_done) m_wait = 0;
            else if (pop) begin
                h = mq.pop_front();
                if (h.op == 4'hF && !h.fill) m_wait = 1;
            end
            if (push) mq.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".stall"}, 32'(stall), 32'(mq.size() == DEPTH));
        chk({tag, ".valid"}, 32'(cmd_valid), 32'(mq.size() != 0 && !m_wait));
        chk({tag, ".err"}, 32'(err_overlap), 32'(m_err));
        if (mq.size() != 0) begin
            chk({tag, ".fill"}, 32'(cmd_fill), 32'(mq[0].fill));
            chk({tag, ".op"}, 32'(cmd_op), 32'(mq[0].op));
            chk({tag, ".code"}, 32'(cmd_code), 32'(mq[0].code));
            chk({tag, ".num"}, 32'(cmd_obj_num), 32'(mq[0].num));
            chk({tag, ".type"}, 32'(cmd_obj_type), 32'(mq[0].typ));
            chk({tag, ".color"}, 32'(cmd_obj_color), 32'(mq[0].color));
            chk({tag, ".v0"}, 32'(cmd_v0), 32'(mq[0].v0));
            chk({tag, ".v3"}, 32'(cmd_v3), 32'(mq[0].v0 + 16'd3));
            chk({tag, ".v7"}, 32'(cmd_v7), 32'(mq[0].v7));
            chk({tag, ".ro"}, 32'(cmd_ro), 32'(mq[0].ro));
        end
    endtask

    initial begin
        int pushed;
        int seen;
        logic [15:0] obs_v0 [$];

        rst = 1'b1;  cmd_ready = 1'b0;  obj_done = 1'b0;
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        check_all("reset");
        chk("reset.v0", 32'(cmd_v0), 32'h0);
        chk("reset.count0", 32'(count), 32'd0);

        // Single DRAW
        present(1'b1, 1'b0, 4'h0, 5'd5, 3'h1, 16'h1234);
        cycle();
        idle();
        chk("draw.valid", 32'(cmd_valid), 32'd1);
        chk("draw.num", 32'(cmd_obj_num), 32'd5);
        chk("draw.v0", 32'(cmd_v0), 32'h1234);
        chk("draw.count", 32'(count), 32'd1);
        check_all("draw");
        cmd_ready = 1'b1;
        cycle();
        cmd_ready = 1'b0;
        chk("draw_pop.count", 32'(count), 32'd0);
        chk("draw_pop.valid", 32'(cmd_valid), 32'd0);

        // Fill to full with the decode stage holding on stall, then drain in order
        pushed = 0;
        for (int i = 0; i < 10 && pushed < 4; i++) begin
            bit acc;
            present(1'b1, 1'b0, 4'h1, 5'd1, 3'h2, 16'(pushed + 1));
            acc = !stall;
            cycle();
            if (acc) pushed++;
        end
        chk("full.stall", 32'(stall), 32'd1);
        chk("full.count", 32'(count), 32'd4);
        present(1'b1, 1'b0, 4'h1, 5'd1, 3'h2, 16'd5);
        cycle();
        chk("held.count", 32'(count), 32'd4);
        chk("held.head", 32'(cmd_v0), 32'd1);
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && obs_v0.size() < 5; i++) begin
            bit acc;
            if (pushed < 5) present(1'b1, 1'b0, 4'h1, 5'd1, 3'h2, 16'd5);
            else idle();
            acc = !stall;
            if (cmd_valid && cmd_ready) obs_v0.push_back(cmd_v0);
            cycle();
            if (acc && pushed < 5) pushed++;
            check_all("drain");
        end
        idle();
        chk("drain.n", 32'(obs_v0.size()), 32'd5);
        seen = obs_v0.size();
        for (int i = 0; i < seen; i++) chk("drain.order", 32'(obs_v0[i]), 32'(i + 1));
        cycle();
        cmd_ready = 1'b0;
        check_all("drain_end");

        // Full with pop and push presented together: pop only
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 1'b0, 4'h2, 5'd2, 3'h3, 16'(16'h30 + i));
            cycle();
        end
        chk("pp.full", 32'(count), 32'd4);
        cmd_ready = 1'b1;
        present(1'b1, 1'b0, 4'h2, 5'd2, 3'h3, 16'h40);
        cycle();
        chk("pp.pop_only", 32'(count), 32'd3);
        cmd_ready = 1'b0;
        cycle();
        chk("pp.repush", 32'(count), 32'd4);
        check_all("pp");
        idle();
        cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check_all("pp_drain");
        chk("pp_drain.count", 32'(count), 32'd0);

        // GETOBJ barrier
        present(1'b1, 1'b0, 4'hF, 5'd7, 3'h0, 16'hAAAA);
        cycle();
        present(1'b1, 1'b0, 4'h3, 5'd8, 3'h0, 16'hBBBB);
        cycle();
        idle();
        for (int i = 0; i < 10; i++) begin
            chk("getobj.hold", 32'(cmd_valid), 32'd0);
            cycle();
        end
        check_all("getobj_wait");
        obj_done = 1'b1;
        cmd_ready = 1'b0;
        cycle();
        obj_done = 1'b0;
        chk("getobj.release", 32'(cmd_valid), 32'd1);
        chk("getobj.tran", 32'(cmd_op), 32'h3);
        chk("getobj.tran_v0", 32'(cmd_v0), 32'hBBBB);
        obj_done = 1'b1;
        cycle();
        obj_done = 1'b0;
        chk("issue_done.valid", 32'(cmd_valid), 32'd1);
        check_all("issue_done");
        cmd_ready = 1'b1;
        cycle();
        chk("tran_pop.count", 32'(count), 32'd0);

        // FILL entries, FILL with op F, overlap error
        cmd_ready = 1'b0;
        present(1'b0, 1'b1, 4'hF, 5'd3, 3'h6, 16'h0F0F);
        cycle();
        idle();
        chk("fill.flag", 32'(cmd_fill), 32'd1);
        chk("fill.color", 32'(cmd_obj_color), 32'h6);
        cmd_ready = 1'b1;
        cycle();
        present(1'b1, 1'b0, 4'h0, 5'd4, 3'h1, 16'h5555);
        cycle();
        idle();
        chk("fill_f.no_wait", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b0;
        present(1'b1, 1'b1, 4'h2, 5'd9, 3'h2, 16'h7777);
        cycle();
        idle();
        chk("overlap.err", 32'(err_overlap), 32'd1);
        chk("overlap.count", 32'(count), 32'd2);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("overlap.sticky", 32'(err_overlap), 32'd1);
        check_all("overlap");

        // Reset mid-operation
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 1'b0, 4'h1, 5'd6, 3'h5, 16'(16'h900 + i));
            cycle();
        end
        idle();
        chk("pre_rst.count", 32'(count), 32'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.valid", 32'(cmd_valid), 32'd0);
        chk("rst.v0", 32'(cmd_v0), 32'd0);
        chk("rst.err", 32'(err_overlap), 32'd0);
        present(1'b1, 1'b0, 4'h0, 5'd1, 3'h1, 16'h4321);
        cycle();
        idle();
        chk("post_rst.valid", 32'(cmd_valid), 32'd1);
        chk("post_rst.v0", 32'(cmd_v0), 32'h4321);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            bit s, f;
            logic [3:0] op;
            r = int'($urandom_range(0, 19));
            s = (r < 8);
            f = (r >= 8 && r < 12) || (r == 19);
            if (r == 19) s = 1'b1;
            op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            present(s, f, op, 5'($urandom), 3'($urandom), 16'($urandom));
            cmd_ready = ($urandom_range(0, 9) < 7);
            obj_done  = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
            rst = 1'b0;
            obj_done = 1'b0;
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
